// File: rtl/uart_tx_pkg.sv
// ----------------------------------------------------------------------------
// uart_tx_pkg
//   Shared definitions for the UART hex/raw transmit front end:
//   MODE bit positions, ASCII constants, the nibble-to-ASCII helper and the
//   serializer state encoding.
//   Optional feature macro used by the importing files: UART_TX_PARITY_EN.
// ----------------------------------------------------------------------------
package uart_tx_pkg;

  // MODE input bit positions
  localparam int MODE_RAW_BIT  = 0;  // 1: send DATA[7:0] as one raw byte
  localparam int MODE_CRLF_BIT = 1;  // 1: append CR LF after the data chars

  // ASCII constants
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_A_M10 = 8'h57;  // 'a' - 10, so 10 maps to 'a'

  // Serializer state encoding (kept as plain constants for legacy tools)
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  // Lowercase hex digit for one nibble
  function automatic logic [7:0] hex_to_ascii(input logic [3:0] nib);
    if (nib < 4'd10) return ASCII_ZERO + {4'h0, nib};
    else             return ASCII_A_M10 + {4'h0, nib};
  endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// ----------------------------------------------------------------------------
// uart_tx_serializer
//   Bit serializer for one 8N1/8N2 (or 8E1/8E2) UART frame. A byte is taken
//   on load_i when idle or in the final stop-bit cycle, so back-to-back
//   frames are contiguous. TXD is driven from a flop.
//   Macro UART_TX_PARITY_EN: adds an even-parity bit after data bit 7.
//
//   Ports:
//     clk          in   clock, rising edge
//     rst_n        in   asynchronous active-low reset
//     byte_i       in   byte to send, sampled when load_i is honoured
//     load_i       in   start a new frame with byte_i
//     txd_o        out  serial line, idles high
//     busy_o       out  frame in progress (any state but IDLE)
//     last_cycle_o out  final clock cycle of the final stop bit
// ----------------------------------------------------------------------------
module uart_tx_serializer
  import uart_tx_pkg::*;
#(
  parameter int CLK_DIV   = 33,
  parameter int STOP_BITS = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] byte_i,
  input  logic       load_i,
  output logic       txd_o,
  output logic       busy_o,
  output logic       last_cycle_o
);

  localparam int              DIV_W     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic            STOP_LAST = 1'(STOP_BITS - 1);

  logic [2:0]       state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [2:0]       bit_q, bit_d;
  logic             stop_q, stop_d;
  logic [7:0]       shift_q, shift_d;
  logic             txd_q, txd_d;
`ifdef UART_TX_PARITY_EN
  logic             parity_q, parity_d;
`endif

  logic bit_end;

  assign bit_end      = (div_q == DIV_LAST);
  assign last_cycle_o = (state_q == ST_STOP) && bit_end && (stop_q == STOP_LAST);
  assign busy_o       = (state_q != ST_IDLE);
  assign txd_o        = txd_q;

  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_d  = state_q;
    div_d    = (state_q == ST_IDLE || bit_end) ? '0 : div_q + 1'b1;
    bit_d    = bit_q;
    stop_d   = stop_q;
    shift_d  = shift_q;
`ifdef UART_TX_PARITY_EN
    parity_d = parity_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (load_i) begin
          state_d  = ST_START;
          shift_d  = byte_i;
`ifdef UART_TX_PARITY_EN
          parity_d = ^byte_i;
`endif
        end
      end
      ST_START: begin
        if (bit_end) begin
          state_d = ST_DATA;
          bit_d   = '0;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
            stop_d  = 1'b0;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (bit_end) state_d = ST_STOP;
      end
`endif
      ST_STOP: begin
        if (bit_end) begin
          if (stop_q == STOP_LAST) begin
            // Chain straight into the next start bit when a byte is waiting
            if (load_i) begin
              state_d  = ST_START;
              shift_d  = byte_i;
`ifdef UART_TX_PARITY_EN
              parity_d = ^byte_i;
`endif
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            stop_d = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Line level follows the next state so TXD comes straight from a flop
    case (state_d)
      ST_START:  txd_d = 1'b0;
      ST_DATA:   txd_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: txd_d = parity_d;
`endif
      default:   txd_d = 1'b1;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples its input from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      div_q    <= '0;
      bit_q    <= '0;
      stop_q   <= 1'b0;
      shift_q  <= '0;
      txd_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      bit_q    <= bit_d;
      stop_q   <= stop_d;
      shift_q  <= shift_d;
      txd_q    <= txd_d;
`ifdef UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

endmodule

// File: rtl/uart_tx_hex_fifo.sv
// ----------------------------------------------------------------------------
// uart_tx_hex_fifo
//   UART transmit front end. Each accepted word is expanded into ASCII hex
//   (lowercase, MS nibble first) or a single raw byte, optionally followed by
//   CR LF. Characters go one per cycle into a byte FIFO that feeds the
//   serializer.
//   Macro UART_TX_PARITY_EN: even parity bit in each frame (in serializer).
//
//   Ports:
//     clk      in   clock, rising edge
//     rst_n    in   asynchronous active-low reset
//     data_i   in   word to send (DATA_W bits)
//     we_i     in   write strobe, honoured only while ready_o=1
//     mode_i   in   bit0 raw byte / hex, bit1 append CR LF
//     txd_o    out  serial line, idles high
//     ready_o  out  loader has no pending characters
//     empty_o  out  FIFO empty
//     full_o   out  FIFO full
//     busy_o   out  serializer transmitting a frame
//     level_o  out  FIFO occupancy
// ----------------------------------------------------------------------------
module uart_tx_hex_fifo
  import uart_tx_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int CLK_DIV    = 33,
  parameter int FIFO_DEPTH = 16,
  parameter int STOP_BITS  = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [DATA_W-1:0]           data_i,
  input  logic                        we_i,
  input  logic [1:0]                  mode_i,
  output logic                        txd_o,
  output logic                        ready_o,
  output logic                        empty_o,
  output logic                        full_o,
  output logic                        busy_o,
  output logic [$clog2(FIFO_DEPTH):0] level_o
);

  localparam int NH        = DATA_W / 4;
  localparam int MAX_CHARS = NH + 2;
  localparam int AW        = $clog2(FIFO_DEPTH);
  localparam int LVL_W     = AW + 1;

  // Loader: pending characters, char 0 in the low byte, with a valid mask
  logic [8*MAX_CHARS-1:0] chars_q, chars_d, chars_load;
  logic [MAX_CHARS-1:0]   valid_q, valid_d, valid_load;

  // FIFO
  logic [7:0]       fifo_mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0] level_q, level_d;
  logic             full_q, empty_q;

  logic accept, push, pop;
  logic ser_busy, ser_last;

  assign ready_o = ~|valid_q;
  assign accept  = we_i & ready_o;
  // A full FIFO blocks the push even if a pop frees a slot this cycle
  assign push    = valid_q[0] & ~full_q;
  assign pop     = ~empty_q & (~ser_busy | ser_last);

  // Character sequence for the word currently on data_i
  always_comb begin
    chars_load = '0;
    valid_load = '0;
    if (mode_i[MODE_RAW_BIT]) begin
      chars_load[7:0] = data_i[7:0];
      valid_load[0]   = 1'b1;
      if (mode_i[MODE_CRLF_BIT]) begin
        chars_load[15:8]  = ASCII_CR;
        chars_load[23:16] = ASCII_LF;
        valid_load[2:1]   = 2'b11;
      end
    end else begin
      for (int i = 0; i < NH; i++) begin
        chars_load[8*i +: 8] = hex_to_ascii(data_i[4*(NH-1-i) +: 4]);
        valid_load[i]        = 1'b1;
      end
      if (mode_i[MODE_CRLF_BIT]) begin
        chars_load[8*NH +: 8]     = ASCII_CR;
        chars_load[8*(NH+1) +: 8] = ASCII_LF;
        valid_load[NH]            = 1'b1;
        valid_load[NH+1]          = 1'b1;
      end
    end
  end

  // accept and push are exclusive: accept needs an empty mask, push a set bit
  always_comb begin
    chars_d = chars_q;
    valid_d = valid_q;
    if (accept) begin
      chars_d = chars_load;
      valid_d = valid_load;
    end else if (push) begin
      chars_d = chars_q >> 8;
      valid_d = valid_q >> 1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chars_q <= '0;
      valid_q <= '0;
    end else begin
      chars_q <= chars_d;
      valid_q <= valid_d;
    end
  end

  // NOTE: the storage array has no reset; entries are only read after being
  // written, and leaving it unreset lets it map onto plain RAM/registers.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= chars_q[7:0];
  end

  assign level_d = level_q + LVL_W'(push) - LVL_W'(pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      level_q <= level_d;
      full_q  <= (level_d == LVL_W'(FIFO_DEPTH));
      empty_q <= (level_d == '0);
    end
  end

  assign level_o = level_q;
  assign full_o  = full_q;
  assign empty_o = empty_q;
  assign busy_o  = ser_busy;

  uart_tx_serializer #(
    .CLK_DIV   (CLK_DIV),
    .STOP_BITS (STOP_BITS)
  ) u_serializer (
    .clk          (clk),
    .rst_n        (rst_n),
    .byte_i       (fifo_mem[rd_ptr_q]),
    .load_i       (pop),
    .txd_o        (txd_o),
    .busy_o       (ser_busy),
    .last_cycle_o (ser_last)
  );

endmodule

// File: tb/tb_uart_tx_hex_fifo.sv
// ----------------------------------------------------------------------------
// tb_uart_tx_hex_fifo
//   Self-checking bench for uart_tx_hex_fifo (DATA_W=32, CLK_DIV=4,
//   FIFO_DEPTH=16, STOP_BITS=1). A line receiver decodes TXD; expected
//   character streams come from a string-formatting model of the word.
//   Honours UART_TX_PARITY_EN for frame length and parity.
// ----------------------------------------------------------------------------
module tb_uart_tx_hex_fifo;

  localparam int DATA_W     = 32;
  localparam int CLK_DIV    = 4;
  localparam int FIFO_DEPTH = 16;
  localparam int STOP_BITS  = 1;
`ifdef UART_TX_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif
  localparam int FRAME_BITS = 1 + 8 + PAR_BITS + STOP_BITS;
  localparam int FRAME_CYC  = FRAME_BITS * CLK_DIV;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [DATA_W-1:0] data = '0;
  logic              we = 1'b0;
  logic [1:0]        mode = '0;
  logic              txd, ready, empty, full, busy;
  logic [4:0]        level;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;

  // Receiver results
  logic [7:0] rx_bytes[$];
  int         rx_start[$];
  int         frame_errs = 0;

  // Status-flag observations
  int max_level = 0;
  bit full_seen = 0;
  int flag_errs = 0;

  // Expected character stream
  logic [7:0] exp_q[$];

  uart_tx_hex_fifo #(
    .DATA_W     (DATA_W),
    .CLK_DIV    (CLK_DIV),
    .FIFO_DEPTH (FIFO_DEPTH),
    .STOP_BITS  (STOP_BITS)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .data_i  (data),
    .we_i    (we),
    .mode_i  (mode),
    .txd_o   (txd),
    .ready_o (ready),
    .empty_o (empty),
    .full_o  (full),
    .busy_o  (busy),
    .level_o (level)
  );

  initial forever #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc++; end

  initial begin
    #500000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "watchdog");
  end

  // Line receiver: samples TXD every cycle on the falling edge; each bit
  // must hold for exactly CLK_DIV samples.
  logic [FRAME_BITS-1:0] mon_bits;
  int                    mon_t0;
  bit                    mon_abort, mon_glitch;
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && txd === 1'b0) begin
        mon_t0     = cyc;
        mon_bits   = '0;
        mon_abort  = 0;
        mon_glitch = 0;
        for (int k = 1; k < FRAME_CYC; k++) begin
          @(negedge clk);
          if (rst_n !== 1'b1) begin
            mon_abort = 1;
            break;
          end
          if (k % CLK_DIV == 0) mon_bits[k / CLK_DIV] = txd;
          else if (txd !== mon_bits[k / CLK_DIV]) mon_glitch = 1;
        end
        if (!mon_abort) begin
          rx_bytes.push_back(mon_bits[8:1]);
          rx_start.push_back(mon_t0);
          if (mon_glitch) frame_errs++;
          if (mon_bits[FRAME_BITS-1 -: STOP_BITS] !== {STOP_BITS{1'b1}}) frame_errs++;
`ifdef UART_TX_PARITY_EN
          if (mon_bits[9] !== ^mon_bits[8:1]) frame_errs++;
`endif
        end
      end
    end
  end

  // FIFO status flags must agree with LEVEL at all times
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin
        if (int'(level) > max_level) max_level = int'(level);
        if (full === 1'b1) full_seen = 1;
        if (full !== (level == 5'(FIFO_DEPTH)) || empty !== (level == 5'd0) ||
            int'(level) > FIFO_DEPTH)
          flag_errs++;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: characters a word should produce on the line
  function automatic int add_expected(input logic [31:0] d, input logic [1:0] m);
    string s;
    int    n0;
    n0 = exp_q.size();
    if (m[0]) begin
      exp_q.push_back(d[7:0]);
    end else begin
      s = $sformatf("%08h", d);
      for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
    end
    if (m[1]) begin
      exp_q.push_back(8'h0D);
      exp_q.push_back(8'h0A);
    end
    return exp_q.size() - n0;
  endfunction

  task automatic send(input logic [31:0] d, input logic [1:0] m, output int acc);
    int guard;
    guard = 0;
    @(negedge clk);
    while (ready !== 1'b1 && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    check("ready_wait_bound", 64'(guard < 5000), 64'd1);
    data = d;
    mode = m;
    we   = 1'b1;
    @(posedge clk);
    #1;
    acc  = cyc;
    we   = 1'b0;
    data = $urandom;
  endtask

  task automatic measure_ready(output int n);
    n = 0;
    while (ready !== 1'b1 && n < 1000) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_idle(input string tag);
    int g;
    g = 0;
    while (!(ready === 1'b1 && empty === 1'b1 && busy === 1'b0) && g < 20000) begin
      @(negedge clk);
      g++;
    end
    repeat (2) @(negedge clk);
    check(tag, 64'(g < 20000), 64'd1);
  endtask

  task automatic check_stream(input string tag, input int base);
    int n;
    n = rx_bytes.size() - base;
    check({tag, "_count"}, 64'(n), 64'(exp_q.size()));
    for (int i = 0; i < n && i < exp_q.size(); i++)
      check($sformatf("%s_byte%0d", tag, i), 64'(rx_bytes[base+i]), 64'(exp_q[i]));
  endtask

  task automatic check_gaps(input string tag, input int base);
    for (int i = base + 1; i < rx_start.size(); i++)
      check($sformatf("%s_gap%0d", tag, i - base), 64'(rx_start[i] - rx_start[i-1]),
            64'(FRAME_CYC));
  endtask

  initial begin
    int acc, n, nexp, base;
    logic [31:0] w;
    logic [1:0]  m;

    // ---- reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_txd",   64'(txd),   64'd1);
    check("rst_ready", 64'(ready), 64'd1);
    check("rst_empty", 64'(empty), 64'd1);
    check("rst_full",  64'(full),  64'd0);
    check("rst_busy",  64'(busy),  64'd0);
    check("rst_level", 64'(level), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // ---- hex word 0x1234ABCD
    exp_q.delete();
    base = rx_bytes.size();
    nexp = add_expected(32'h1234ABCD, 2'b00);
    send(32'h1234ABCD, 2'b00, acc);
    measure_ready(n);
    check("hex_ready_low", 64'(n), 64'(nexp));
    wait_idle("hex_idle");
    check_stream("hex", base);
    check("hex_first_start", 64'(rx_start[base]), 64'(acc + 2));
    check_gaps("hex", base);

    // ---- raw 0x41: exact frame timing
    exp_q.delete();
    base = rx_bytes.size();
    nexp = add_expected(32'hDEAD_BE41, 2'b01);
    send(32'hDEAD_BE41, 2'b01, acc);
    measure_ready(n);
    check("raw_ready_low", 64'(n), 64'(nexp));
    check("raw_txd_before_start", 64'(txd), 64'd1);
    wait_until(acc + 2);
    check("raw_start_low", 64'(txd), 64'd0);
    check("raw_busy_start", 64'(busy), 64'd1);
    wait_until(acc + 2 + FRAME_CYC - 1);
    check("raw_busy_last", 64'(busy), 64'd1);
    wait_until(acc + 2 + FRAME_CYC);
    check("raw_busy_end", 64'(busy), 64'd0);
    check("raw_txd_end", 64'(txd), 64'd1);
    wait_idle("raw_idle");
    check_stream("raw", base);

    // ---- raw + CR LF, contiguous frames
    exp_q.delete();
    base = rx_bytes.size();
    nexp = add_expected(32'h0000_005A, 2'b11);
    send(32'h0000_005A, 2'b11, acc);
    measure_ready(n);
    check("crlf_ready_low", 64'(n), 64'(nexp));
    wait_idle("crlf_idle");
    check_stream("crlf", base);
    check_gaps("crlf", base);

    // ---- randomized words and modes
    for (int t = 0; t < 6; t++) begin
      exp_q.delete();
      base = rx_bytes.size();
      w = $urandom;
      m = 2'($urandom_range(3, 0));
      nexp = add_expected(w, m);
      send(w, m, acc);
      measure_ready(n);
      check($sformatf("rnd%0d_ready_low", t), 64'(n), 64'(nexp));
      wait_idle($sformatf("rnd%0d_idle", t));
      check_stream($sformatf("rnd%0d", t), base);
      if (rx_bytes.size() > base)
        check($sformatf("rnd%0d_first_start", t), 64'(rx_start[base]), 64'(acc + 2));
      check_gaps($sformatf("rnd%0d", t), base);
    end

    // ---- three hex words back to back: FIFO fills, ignored writes
    exp_q.delete();
    base = rx_bytes.size();
    for (int t = 0; t < 3; t++) begin
      w = $urandom;
      nexp = add_expected(w, 2'b00);
      send(w, 2'b00, acc);
      @(negedge clk);
      check($sformatf("burst%0d_ready_low", t), 64'(ready), 64'd0);
      we   = 1'b1;
      data = $urandom;
      mode = 2'($urandom_range(3, 0));
      @(posedge clk);
      #1;
      we = 1'b0;
    end
    wait_idle("burst_idle");
    check_stream("burst", base);
    check_gaps("burst", base);
    check("burst_full_seen", 64'(full_seen), 64'd1);
    check("burst_max_level", 64'(max_level), 64'(FIFO_DEPTH));

    // ---- reset during data bit 3 of 'A'
    base = rx_bytes.size();
    send(32'h0000_0041, 2'b01, acc);
    wait_until(acc + 2 + 4 * CLK_DIV + 1);
    check("rstmid_bit3", 64'(txd), 64'd0);  // bit 3 of 0x41
    rst_n = 1'b0;
    #1;
    check("rstmid_txd",   64'(txd),   64'd1);
    check("rstmid_busy",  64'(busy),  64'd0);
    check("rstmid_empty", 64'(empty), 64'd1);
    check("rstmid_level", 64'(level), 64'd0);
    check("rstmid_ready", 64'(ready), 64'd1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (FRAME_CYC + 5) @(negedge clk);
    check("rstmid_no_resend", 64'(rx_bytes.size() - base), 64'd0);
    check("rstmid_idle_busy", 64'(busy), 64'd0);
    exp_q.delete();
    nexp = add_expected(32'h0000_0042, 2'b01);
    send(32'h0000_0042, 2'b01, acc);
    wait_idle("rstmid_idle");
    check_stream("after_rst", base);

    // ---- receiver and flag consistency over the whole run
    check("frame_errors", 64'(frame_errs), 64'd0);
    check("flag_consistency", 64'(flag_errs), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
